// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for serial_adder_ctrl.
// The sub line exists only when SERIAL_ADDER_SUB_EN is defined.
`timescale 1ns/1ps
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one FullAdder walks a WIDTH-bit operand pair LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub request (two's-complement subtract).
`timescale 1ns/1ps
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                clock,
  input logic                reset,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             s_bit, c_bit;

  FullAdder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (s_bit),
    .cout (c_bit)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_sh_d  = bus.a;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
          // Subtract as a + ~b + 1; cin is deliberately ignored here.
          b_sh_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? 1'b1 : bus.cin;
`else
          b_sh_d  = bus.b;
          carry_d = bus.cin;
`endif
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {s_bit, sum_q[WIDTH-1:1]};
        carry_d = c_bit;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        cout_d  = carry_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered from the next state so busy tracks RUN/DONE without a combinational output.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=4 against an arithmetic reference.
// Subtract scenarios run only when SERIAL_ADDER_SUB_EN is defined.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;
  localparam int W        = 4;
  localparam int MASK     = (1 << W) - 1;
  localparam int DONE_LAT = W + 1;
  localparam int BUSY_LEN = W + 1;
  localparam int PERIOD   = W + 2;
  localparam int WINDOW   = W + 5;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Launch one request and watch a bounded window; samples taken at negedges.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic ocin, input logic osub,
                        output int done_at, output int done_cnt, output int busy_cnt,
                        output logic [W:0] res, output logic [W:0] res_end);
    @(negedge clock);
    bus.start = 1'b1;
    bus.a     = oa;
    bus.b     = ob;
    bus.cin   = ocin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = osub;
`else
    if (osub) $display("[TB] sub request ignored in add-only build");
`endif
    done_at  = -1;
    done_cnt = 0;
    busy_cnt = 0;
    res      = '0;
    for (int k = 0; k < WINDOW; k++) begin
      @(negedge clock);
      if (k == 0) begin
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          res     = {bus.cout, bus.sum};
        end
      end
    end
    res_end = {bus.cout, bus.sum};
  endtask

  function automatic logic [W:0] add_ref(input int x, input int y, input int c);
    return (W+1)'(x + y + c);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks += 4;
    if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", bus.done); end
    if (bus.sum !== '0) begin failures++; $display("[TB] FAIL reset_sum got=%h exp=0", bus.sum); end
    if (bus.cout !== 1'b0) begin failures++; $display("[TB] FAIL reset_cout got=%b exp=0", bus.cout); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int da, dc, bc;
    logic [W:0] r, re;
    run_op(4'h3, 4'h5, 1'b0, 1'b0, da, dc, bc, r, re);
    checks += 5;
    if (da != DONE_LAT) begin failures++; $display("[TB] FAIL basic_done_time got=%0d exp=%0d", da, DONE_LAT); end
    if (dc != 1) begin failures++; $display("[TB] FAIL basic_done_count got=%0d exp=1", dc); end
    if (bc != BUSY_LEN) begin failures++; $display("[TB] FAIL basic_busy_len got=%0d exp=%0d", bc, BUSY_LEN); end
    if (r !== 5'h08) begin failures++; $display("[TB] FAIL basic_result got=%h exp=08", r); end
    if (re !== 5'h08) begin failures++; $display("[TB] FAIL basic_hold got=%h exp=08", re); end
  endtask

  task automatic test_wrap();
    int da, dc, bc;
    logic [W:0] r, re;
    run_op(4'hF, 4'h1, 1'b0, 1'b0, da, dc, bc, r, re);
    checks++;
    if (r !== 5'h10) begin failures++; $display("[TB] FAIL wrap_f_plus_1 got=%h exp=10", r); end
    run_op(4'hF, 4'hF, 1'b1, 1'b0, da, dc, bc, r, re);
    checks++;
    if (r !== 5'h1F) begin failures++; $display("[TB] FAIL wrap_f_plus_f_cin got=%h exp=1f", r); end
  endtask

  task automatic test_random();
    int da, dc, bc, x, y, c;
    logic [W:0] r, re, e;
    for (int i = 0; i < 12; i++) begin
      x = int'($urandom_range(0, MASK));
      y = int'($urandom_range(0, MASK));
      c = int'($urandom_range(0, 1));
      e = add_ref(x, y, c);
      run_op(W'(x), W'(y), 1'(c), 1'b0, da, dc, bc, r, re);
      checks += 3;
      if (r !== e) begin failures++; $display("[TB] FAIL rand_result a=%h b=%h cin=%0d got=%h exp=%h", x, y, c, r, e); end
      if (da != DONE_LAT || dc != 1) begin failures++; $display("[TB] FAIL rand_done at=%0d count=%0d exp at=%0d count=1", da, dc, DONE_LAT); end
      if (re !== e) begin failures++; $display("[TB] FAIL rand_hold got=%h exp=%h", re, e); end
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt = 0;
    int done_at = -1;
    logic [W:0] r = '0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.a = 4'h3;
    bus.b = 4'h5;
    bus.cin = 1'b0;
    for (int k = 0; k < WINDOW + 6; k++) begin
      @(negedge clock);
      bus.start = (k == 1);
      if (k == 1) begin
        bus.a = 4'hF;
        bus.b = 4'hE;
        bus.cin = 1'b1;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          r = {bus.cout, bus.sum};
        end
      end
    end
    checks += 3;
    if (done_cnt != 1) begin failures++; $display("[TB] FAIL ignore_done_count got=%0d exp=1", done_cnt); end
    if (done_at != DONE_LAT) begin failures++; $display("[TB] FAIL ignore_done_time got=%0d exp=%0d", done_at, DONE_LAT); end
    if (r !== 5'h08) begin failures++; $display("[TB] FAIL ignore_result got=%h exp=08", r); end
  endtask

  task automatic test_held_start();
    int pos[$];
    int k_last = 0;
    logic bad_sum = 1'b0;
    @(negedge clock);
    bus.start = 1'b1;
    bus.a = 4'h1;
    bus.b = 4'h1;
    bus.cin = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        pos.push_back(k);
        if ({bus.cout, bus.sum} !== 5'h02) bad_sum = 1'b1;
      end
    end
    bus.start = 1'b0;
    repeat (WINDOW) @(negedge clock);
    checks += 3;
    if (pos.size() != 3) begin failures++; $display("[TB] FAIL held_done_count got=%0d exp=3", pos.size()); end
    for (int i = 0; i < pos.size(); i++) begin
      if (pos[i] != DONE_LAT + i * PERIOD) k_last = pos[i] + 1000 * (i + 1);
    end
    if (k_last != 0) begin failures++; $display("[TB] FAIL held_done_spacing got code=%0d exp=0 (pulses at %0d + n*%0d)", k_last, DONE_LAT, PERIOD); end
    if (bad_sum) begin failures++; $display("[TB] FAIL held_result got=bad exp=02"); end
  endtask

  task automatic test_reset_mid_run();
    int dc = 0;
    int da, bc;
    logic [W:0] r, re;
    @(negedge clock);
    bus.start = 1'b1;
    bus.a = 4'h9;
    bus.b = 4'h6;
    bus.cin = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks += 4;
    if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy got=%b exp=0", bus.busy); end
    if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL midreset_done got=%b exp=0", bus.done); end
    if (bus.sum !== '0) begin failures++; $display("[TB] FAIL midreset_sum got=%h exp=0", bus.sum); end
    if (bus.cout !== 1'b0) begin failures++; $display("[TB] FAIL midreset_cout got=%b exp=0", bus.cout); end
    for (int k = 0; k < WINDOW; k++) begin
      @(negedge clock);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dc++;
    end
    checks++;
    if (dc != 0) begin failures++; $display("[TB] FAIL midreset_no_done got=%0d exp=0", dc); end
    run_op(4'h2, 4'h2, 1'b0, 1'b0, da, bc, bc, r, re);
    checks += 2;
    if (r !== 5'h04) begin failures++; $display("[TB] FAIL midreset_fresh got=%h exp=04", r); end
    if (da != DONE_LAT) begin failures++; $display("[TB] FAIL midreset_fresh_time got=%0d exp=%0d", da, DONE_LAT); end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    int da, dc, bc, x, y;
    logic [W:0] r, re, e;
    run_op(4'h5, 4'h3, 1'b0, 1'b1, da, dc, bc, r, re);
    checks++;
    if (r !== 5'h12) begin failures++; $display("[TB] FAIL sub_5_3 got=%h exp=12", r); end
    run_op(4'h3, 4'h5, 1'b1, 1'b1, da, dc, bc, r, re);
    checks++;
    if (r !== 5'h0E) begin failures++; $display("[TB] FAIL sub_3_5 got=%h exp=0e", r); end
    for (int i = 0; i < 8; i++) begin
      x = int'($urandom_range(0, MASK));
      y = int'($urandom_range(0, MASK));
      e = {1'(x >= y), W'((x - y) & MASK)};
      run_op(W'(x), W'(y), 1'($urandom), 1'b1, da, dc, bc, r, re);
      checks++;
      if (r !== e) begin failures++; $display("[TB] FAIL sub_rand a=%h b=%h got=%h exp=%h", x, y, r, e); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_ignore_start();
    test_held_start();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
